// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 reference state encoding and register constants.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam int         IDCODE_W  = 32;
  localparam logic [3:0] BYPASS_OP = 4'b1111;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: next-state logic, state register and DR-phase decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_t state_q,
  output tap_state_t state_d,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TEST_LOGIC_RESET;
    else        state_q <= state_d;
  end

  assign capture_dr = (state_q == CAPTURE_DR);
  assign shift_dr   = (state_q == SHIFT_DR);
  assign update_dr  = (state_q == UPDATE_DR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP: FSM plus IR, IDCODE/BYPASS data registers and registered tdo/tdo_en.
// Define USERCODE_EN to add a USERCODE data register on opcode all-ones minus one.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_W         = 4,
  parameter logic [IDCODE_W-1:0] IDCODE_VAL   = 32'h1234_5679,
  parameter logic [IR_W-1:0]     IDCODE_OP    = {{(IR_W-1){1'b0}}, 1'b1},
  parameter logic [IDCODE_W-1:0] USERCODE_VAL = 32'h0000_0000
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_out,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr
);

  tap_state_t          state_q, state_d;
  logic [IR_W-1:0]     ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [IDCODE_W-1:0] dr_shift_q, dr_shift_d, wide_capture;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic                sel_wide;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .tms        (tms),
    .state_q    (state_q),
    .state_d    (state_d),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

`ifdef USERCODE_EN
  localparam logic [IR_W-1:0] USERCODE_OP = {{(IR_W-1){1'b1}}, 1'b0};
`endif

  // The 32-bit shifter is shared by IDCODE and USERCODE; only the capture value differs.
  always_comb begin
    sel_wide     = 1'b0;
    wide_capture = IDCODE_VAL;
    if (ir_q == IDCODE_OP) begin
      sel_wide = 1'b1;
    end
`ifdef USERCODE_EN
    else if (ir_q == USERCODE_OP) begin
      sel_wide     = 1'b1;
      wide_capture = USERCODE_VAL;
    end
`endif
  end

  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    dr_shift_d = dr_shift_q;
    bypass_d   = bypass_q;
    tdo_d      = 1'b0;
    tdo_en_d   = 1'b0;
    case (state_q)
      CAPTURE_IR: ir_shift_d = IR_W'(2'b01);
      SHIFT_IR: begin
        tdo_d      = ir_shift_q[0];
        tdo_en_d   = 1'b1;
        ir_shift_d = {tdi, ir_shift_q[IR_W-1:1]};
      end
      UPDATE_IR: ir_d = ir_shift_q;
      CAPTURE_DR: begin
        if (sel_wide) dr_shift_d = wide_capture;
        else          bypass_d   = 1'b0;
      end
      SHIFT_DR: begin
        tdo_en_d = 1'b1;
        if (sel_wide) begin
          tdo_d      = dr_shift_q[0];
          dr_shift_d = {tdi, dr_shift_q[IDCODE_W-1:1]};
        end else begin
          tdo_d    = bypass_q;
          bypass_d = tdi;
        end
      end
      default: ;
    endcase
    // Reload on the edge that enters TLR so ir_out is already valid in that state.
    if (state_d == TEST_LOGIC_RESET) ir_d = IDCODE_OP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= IDCODE_OP;
      ir_shift_q <= '0;
      dr_shift_q <= '0;
      bypass_q   <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      dr_shift_q <= dr_shift_d;
      bypass_q   <= bypass_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign tdo       = tdo_q;
  assign tdo_en    = tdo_en_q;
  assign tap_state = state_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: queue-based TAP model, directed scans then random operations.
module tb_jtag_tap_ctrl;

  localparam int          IR_W = 4;
  localparam logic [31:0] IDV  = 32'h1234_5679;
  localparam logic [31:0] UCV  = 32'h0000_0000;
  localparam logic [3:0]  IDOP = 4'b0001;
  localparam logic [3:0]  UCOP = 4'b1110;

  localparam int TLR = 15, RTI = 12, SELDR = 7, CAPDR = 6, SHDR = 2, EX1DR = 1, PSDR = 3, EX2DR = 0;
  localparam int UPDR = 5, SELIR = 4, CAPIR = 14, SHIR = 10, EX1IR = 9, PSIR = 11, EX2IR = 8, UPIR = 13;

  logic clk = 1'b0, rst_n = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic tdo, tdo_en, capture_dr, shift_dr, update_dr;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_out;

  jtag_tap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state(tap_state), .ir_out(ir_out), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      st;
    logic [IR_W-1:0] ir;
    logic            tdo;
    logic            en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;

  int              m_state = TLR;
  logic [IR_W-1:0] m_ir = IDOP;
  bit              m_irq[$];
  bit              m_drq[$];

  function automatic int next_state(int s, bit t);
    case (s)
      TLR:   return t ? TLR   : RTI;
      RTI:   return t ? SELDR : RTI;
      SELDR: return t ? SELIR : CAPDR;
      CAPDR: return t ? EX1DR : SHDR;
      SHDR:  return t ? EX1DR : SHDR;
      EX1DR: return t ? UPDR  : PSDR;
      PSDR:  return t ? EX2DR : PSDR;
      EX2DR: return t ? UPDR  : SHDR;
      UPDR:  return t ? SELDR : RTI;
      SELIR: return t ? TLR   : CAPIR;
      CAPIR: return t ? EX1IR : SHIR;
      SHIR:  return t ? EX1IR : SHIR;
      EX1IR: return t ? UPIR  : PSIR;
      PSIR:  return t ? EX2IR : PSIR;
      EX2IR: return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Shift registers are modelled as bit queues: front is the bit next presented on tdo.
  task automatic model_step(bit t, bit d);
    exp_t e;
    e.en  = (m_state == SHIR) || (m_state == SHDR);
    e.tdo = 1'b0;
    case (m_state)
      CAPIR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) m_irq.push_back(1'b0);
      end
      SHIR: begin
        e.tdo = m_irq.pop_front();
        m_irq.push_back(d);
      end
      UPIR: for (int i = 0; i < IR_W; i++) m_ir[i] = m_irq[i];
      CAPDR: begin
        m_drq.delete();
        if (m_ir == IDOP) for (int i = 0; i < 32; i++) m_drq.push_back(IDV[i]);
`ifdef USERCODE_EN
        else if (m_ir == UCOP) for (int i = 0; i < 32; i++) m_drq.push_back(UCV[i]);
`endif
        else m_drq.push_back(1'b0);
      end
      SHDR: begin
        e.tdo = m_drq.pop_front();
        m_drq.push_back(d);
      end
      default: ;
    endcase
    m_state = next_state(m_state, t);
    if (m_state == TLR) m_ir = IDOP;
    e.st = 4'(m_state);
    e.ir = m_ir;
    exp_q.push_back(e);
  endtask

  task automatic step(bit t, bit d);
    @(negedge clk);
    tms = t;
    tdi = d;
    model_step(t, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(tap_state), 32'd15);
    chk("rst_ir", 32'(ir_out), 32'(IDOP));
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    m_state = TLR;
    m_ir    = IDOP;
    m_irq.delete();
    m_drq.delete();
    @(negedge clk);
    tms   = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic goto_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI/UPDATE: full scan of len bits (LSB first), ending back in RTI.
  task automatic scan(bit is_ir, int len, logic [63:0] bits);
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < len; i++) step(i == len - 1, bits[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn state=%h ir=%h tdo=%b tdo_en=%b", tap_state, ir_out, tdo, tdo_en);
        chk("state", 32'(tap_state), 32'(e.st));
        chk("ir_out", 32'(ir_out), 32'(e.ir));
        chk("tdo_en", 32'(tdo_en), 32'(e.en));
        chk("tdo", 32'(tdo), 32'(e.tdo));
        chk("capture_dr", 32'(capture_dr), 32'(e.st == 4'(CAPDR)));
        chk("shift_dr", 32'(shift_dr), 32'(e.st == 4'(SHDR)));
        chk("update_dr", 32'(update_dr), 32'(e.st == 4'(UPDR)));
      end
    end
  end

  initial begin
    logic [3:0] op;
    do_reset();
    // IDCODE read straight out of TLR
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(i == 31, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    // load BYPASS, then push 1,0,1,1,0 through it
    scan(1'b1, 4, 64'hF);
    scan(1'b0, 5, 64'b01101);
    // forced reset out of SHIFT_DR
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    // async reset after two SHIFT_IR bits
    goto_rti();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0);
    repeat (60) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 3))
            0: op = IDOP;
            1: op = 4'hF;
            2: op = UCOP;
            default: op = 4'($urandom);
          endcase
          scan(1'b1, 4, {60'd0, op});
        end
        1: scan(1'b0, $urandom_range(1, 40), {$urandom, $urandom});
        2: begin
          repeat (12) step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
          goto_rti();
        end
        default: begin
          repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
          do_reset();
          step(1'b0, 1'b0);
        end
      endcase
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
